pokey_keyboard_scan: RTL and testbench

POKEY keyboard scanner and debouncer, the consumer of the keyboard scan-rate enable produced by the clock generator core.
- Steps a 6-bit scan address across the 64-key matrix, one address per keybClk pulse.
- Samples the key-return lines at each address and runs the POKEY compare/debounce state machine.
- Produces KBCODE, the SKSTAT key-down and shift bits, the keyboard IRQ pulse and the BREAK IRQ pulse for the register/IRQ block.

---
 rtl/pokey_keyboard_scan.sv | 110 +++++++++++
 tb/tb_pokey_keyboard_scan.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pokey_keyboard_scan.sv
// POKEY keyboard scanner: walks the 64-key matrix, latches modifiers and
// runs the compare/debounce FSM that produces KBCODE, key-down and IRQ pulses.
module pokey_keyboard_scan #(
  parameter logic [5:0] SHIFT_ADDR = 6'h10,
  parameter logic [5:0] CTRL_ADDR  = 6'h00,
  parameter logic [5:0] BREAK_ADDR = 6'h30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keybClk,
  input  logic       init,
  input  logic       scanEn,
  input  logic       debounceEn,
  input  logic       kr1,
  input  logic       kr2,
  output logic [5:0] k,
  output logic [7:0] kbcode,
  output logic       keyDown,
  output logic       shiftDown,
  output logic       keyIrq,
  output logic       breakIrq
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  state_t     st;
  logic [5:0] cmp;
  logic       ctrl, brk;
  logic       pressed, mod, at_cmp;

  assign pressed = ~kr1;
  assign mod     = ~kr2;
  assign at_cmp  = (k == cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      kbcode    <= '0;
      keyDown   <= 1'b0;
      shiftDown <= 1'b0;
      keyIrq    <= 1'b0;
      breakIrq  <= 1'b0;
      st        <= IDLE;
      cmp       <= '0;
      ctrl      <= 1'b0;
      brk       <= 1'b0;
    end else begin
      keyIrq   <= 1'b0;
      breakIrq <= 1'b0;
      if (init) begin
        k         <= '0;
        st        <= IDLE;
        keyDown   <= 1'b0;
        shiftDown <= 1'b0;
        ctrl      <= 1'b0;
        brk       <= 1'b0;
      end else if (!scanEn) begin
        st      <= IDLE;
        keyDown <= 1'b0;
      end else if (keybClk) begin
        k <= k + 6'd1;
        if (k == SHIFT_ADDR) shiftDown <= mod;
        if (k == CTRL_ADDR)  ctrl      <= mod;
        if (k == BREAK_ADDR) begin
          brk      <= mod;
          breakIrq <= mod & ~brk;
        end
        // Accept paths read ctrl/shiftDown before this step's modifier update.
        case (st)
          IDLE: if (pressed) begin
            if (debounceEn) begin
              cmp <= k;
              st  <= DEBOUNCE;
            end else begin
              kbcode  <= {ctrl, shiftDown, k};
              keyDown <= 1'b1;
              cmp     <= k;
              keyIrq  <= 1'b1;
              st      <= HELD;
            end
          end
          DEBOUNCE: if (at_cmp) begin
            if (pressed) begin
              kbcode  <= {ctrl, shiftDown, k};
              keyDown <= 1'b1;
              keyIrq  <= 1'b1;
              st      <= HELD;
            end else begin
              st <= IDLE;
            end
          end
          HELD: if (at_cmp && !pressed) begin
            if (debounceEn) st <= RELEASE;
            else begin
              keyDown <= 1'b0;
              st      <= IDLE;
            end
          end
          RELEASE: if (at_cmp) begin
            if (pressed) st <= HELD;
            else begin
              keyDown <= 1'b0;
              st      <= IDLE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pokey_keyboard_scan.sv
// Randomised bench for pokey_keyboard_scan against a key-matrix level model.
module tb_pokey_keyboard_scan;
  logic       clk = 1'b0;
  logic       reset = 1'b1, keybClk = 1'b0, init = 1'b0, scanEn = 1'b1, debounceEn = 1'b1;
  logic       kr1 = 1'b1, kr2 = 1'b1;
  logic [5:0] k;
  logic [7:0] kbcode;
  logic       keyDown, shiftDown, keyIrq, breakIrq;

  pokey_keyboard_scan dut (
    .clk(clk), .reset(reset), .keybClk(keybClk), .init(init), .scanEn(scanEn),
    .debounceEn(debounceEn), .kr1(kr1), .kr2(kr2), .k(k), .kbcode(kbcode),
    .keyDown(keyDown), .shiftDown(shiftDown), .keyIrq(keyIrq), .breakIrq(breakIrq)
  );

  always #5 clk = ~clk;

  bit keymat[64];
  bit modmat[64];
  int vectors = 0, miscompares = 0;
  int dk_cnt = 0, db_cnt = 0;
  bit chk_en = 0;

  // Model: which key is pending debounce / held, as plain key indices.
  logic [5:0] m_k = 0;
  logic [7:0] m_kbcode = 0;
  bit m_kd = 0, m_sd = 0, m_kirq = 0, m_birq = 0, m_ctrl = 0, m_brk = 0;
  int pend = -1, held = -1;
  bit relwait = 0;

  task automatic model_step();
    int a;
    bit p, m, oc, os, acc;
    m_kirq = 0; m_birq = 0;
    if (reset) begin
      m_k = 0; m_kbcode = 0; m_kd = 0; m_sd = 0; m_ctrl = 0; m_brk = 0;
      pend = -1; held = -1; relwait = 0;
    end else if (init) begin
      m_k = 0; m_kd = 0; m_sd = 0; m_ctrl = 0; m_brk = 0;
      pend = -1; held = -1; relwait = 0;
    end else if (!scanEn) begin
      m_kd = 0; pend = -1; held = -1; relwait = 0;
    end else if (keybClk) begin
      a = int'(m_k); p = !kr1; m = !kr2; oc = m_ctrl; os = m_sd;
      if (held >= 0) begin
        if (a == held) begin
          if (relwait) begin
            relwait = 0;
            if (!p) begin held = -1; m_kd = 0; end
          end else if (!p) begin
            if (debounceEn) relwait = 1;
            else begin held = -1; m_kd = 0; end
          end
        end
      end else begin
        acc = 0;
        if (pend >= 0) begin
          if (a == pend) begin pend = -1; acc = p; end
        end else if (p) begin
          if (debounceEn) pend = a; else acc = 1;
        end
        if (acc) begin
          m_kbcode = {oc, os, m_k}; m_kd = 1; held = a; relwait = 0; m_kirq = 1;
        end
      end
      if (a == 16) m_sd = m;
      if (a == 0) m_ctrl = m;
      if (a == 48) begin m_birq = m && !m_brk; m_brk = m; end
      m_k = m_k + 6'd1;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      vectors++;
      if ({k, kbcode, keyDown, shiftDown, keyIrq, breakIrq} !==
          {m_k, m_kbcode, m_kd, m_sd, m_kirq, m_birq}) begin
        miscompares++;
        $display("FAIL cycle t=%0t dut k=%h kbcode=%h kd=%b sd=%b kirq=%b birq=%b | want k=%h kbcode=%h kd=%b sd=%b kirq=%b birq=%b",
                 $time, k, kbcode, keyDown, shiftDown, keyIrq, breakIrq,
                 m_k, m_kbcode, m_kd, m_sd, m_kirq, m_birq);
      end
      if (keyIrq === 1'b1) dk_cnt++;
      if (breakIrq === 1'b1) db_cnt++;
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input bit kb);
    keybClk = kb;
    kr1 = !keymat[m_k];
    kr2 = !modmat[m_k];
    model_step();
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 2)) tick(0);
      tick(1);
    end
  endtask

  task automatic clear_mat();
    for (int i = 0; i < 64; i++) begin keymat[i] = 0; modmat[i] = 0; end
  endtask

  initial begin
    clear_mat();
    chk_en = 1;
    reset = 1; tick(0); tick(0); reset = 0;
    lit("rst_k", k, 0); lit("rst_kbcode", kbcode, 0); lit("rst_keydown", keyDown, 0);
    lit("rst_irq", {keyIrq, breakIrq}, 0);

    step_n(70);
    lit("wrap_k", k, 6); lit("model_wrap_k", m_k, 6);
    lit("wrap_kbcode", kbcode, 0); lit("wrap_irqs", dk_cnt + db_cnt, 0);

    debounceEn = 1; keymat[6'h15] = 1;
    step_n(130);
    lit("acc_kbcode", kbcode, 8'h15); lit("acc_keydown", keyDown, 1); lit("acc_irqcnt", dk_cnt, 1);

    keymat[6'h15] = 0; step_n(64);
    keymat[6'h15] = 1; step_n(64);
    lit("glitch_keydown", keyDown, 1); lit("glitch_irqcnt", dk_cnt, 1);
    keymat[6'h15] = 0; step_n(130);
    lit("rel_keydown", keyDown, 0); lit("model_rel_keydown", m_kd, 0);

    modmat[6'h10] = 1; modmat[6'h00] = 1; keymat[6'h15] = 1;
    step_n(200);
    lit("mod_kbcode", kbcode, 8'hD5); lit("mod_shift", shiftDown, 1); lit("mod_irqcnt", dk_cnt, 2);

    clear_mat(); step_n(130);
    lit("clr_keydown", keyDown, 0); lit("clr_shift", shiftDown, 0);
    keymat[6'h15] = 1; step_n(64);
    keymat[6'h15] = 0; step_n(130);
    lit("bounce_irqcnt", dk_cnt, 2); lit("bounce_keydown", keyDown, 0); lit("bounce_kbcode", kbcode, 8'hD5);

    modmat[6'h30] = 1; step_n(192);
    lit("break_cnt", db_cnt, 1);
    modmat[6'h30] = 0; step_n(64);

    keymat[6'h15] = 1; step_n(200);
    lit("held_irqcnt", dk_cnt, 3); lit("held_kbcode", kbcode, 8'h15);
    init = 1; tick(1); tick(1); tick(0);
    lit("init_k", k, 0); lit("init_keydown", keyDown, 0);
    lit("init_kbcode", kbcode, 8'h15); lit("init_irqcnt", dk_cnt, 3);
    init = 0; clear_mat();

    for (int blk = 0; blk < 30; blk++) begin
      clear_mat();
      for (int i = 0; i < 64; i++) keymat[i] = ($urandom_range(0, 39) == 0);
      modmat[0] = $urandom_range(0, 1); modmat[16] = $urandom_range(0, 1);
      modmat[48] = $urandom_range(0, 1);
      debounceEn = $urandom_range(0, 1);
      for (int t = 0; t < 500; t++) begin
        if ($urandom_range(0, 99) == 0) keymat[$urandom_range(0, 63)] ^= 1'b1;
        if ($urandom_range(0, 149) == 0) modmat[$urandom_range(0, 3) * 16] ^= 1'b1;
        reset  = ($urandom_range(0, 999) == 0);
        init   = ($urandom_range(0, 199) == 0);
        scanEn = ($urandom_range(0, 49) != 0);
        tick($urandom_range(0, 2) == 0);
      end
    end
    reset = 0; init = 0; scanEn = 1;
    tick(0);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
